regfile_writeback: RTL and testbench
====================================

REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5: register address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: register data width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 3: consecutive ALU-loss cycles before ALU gets priority; legal range 1..15.
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port stall  in  1  writeback freeze; no acceptance while high.
REQ-007 SHALL have ports alu_valid in 1, alu_ready out 1, alu_waddr in ADDR_WIDTH, alu_wdata in DATA_WIDTH: ALU result producer.
REQ-008 SHALL have ports lsu_valid in 1, lsu_ready out 1, lsu_waddr in ADDR_WIDTH, lsu_wdata in DATA_WIDTH: load result producer.
REQ-009 SHALL have ports rf_wen out 1, rf_waddr out ADDR_WIDTH, rf_wdata out DATA_WIDTH: write port into the register file.
REQ-010 SHALL have port starve_cnt  out  4  current ALU starvation count, for debug.

Function
REQ-011 Transfer on a port SHALL occur when valid and ready are both high at a rising clk edge.
REQ-012 At most one of alu_ready, lsu_ready SHALL be high in any cycle; both SHALL be low while stall is high.
REQ-013 ready SHALL be combinational from valid, stall and arbiter state; ready SHALL never be high for a port whose valid is low.
REQ-014 Arbiter SHALL be a two-state FSM: LSU_PRI (reset state) and ALU_PRI.
REQ-015 In LSU_PRI with stall low: lsu_valid wins; else alu_valid wins; else no grant.
REQ-016 In ALU_PRI with stall low: alu_valid wins; else lsu_valid wins.
REQ-017 starve_cnt SHALL increment (saturating at STARVE_LIMIT) each cycle alu_valid is high, stall is low and the ALU is not granted; it SHALL clear on an ALU grant.
REQ-018 starve_cnt SHALL hold during stall.
REQ-019 FSM SHALL go LSU_PRI -> ALU_PRI on the edge where starve_cnt next value equals STARVE_LIMIT; ALU_PRI -> LSU_PRI on the edge of an ALU grant.
REQ-020 An accepted write SHALL appear on rf_waddr/rf_wdata with rf_wen high exactly one cycle after acceptance (registered output, latency 1).
REQ-021 rf_wen SHALL be a single-cycle pulse per accepted write; with back-to-back acceptances it SHALL stay high continuously.
REQ-022 A write with waddr = 0 SHALL be accepted normally (ready handshake completes) but SHALL produce rf_wen = 0 in the following cycle.
REQ-023 rf_waddr/rf_wdata SHALL hold their last value when rf_wen is low.
REQ-024 Stall asserted in the cycle after an acceptance SHALL NOT suppress the pending rf_wen pulse already registered.
REQ-025 Producer data held stable under valid without ready SHALL be written exactly once after eventual acceptance; no duplication, no loss.

Reset
REQ-026 On rst low, immediately and independent of clk: rf_wen = 0, rf_waddr = 0, rf_wdata = 0, starve_cnt = 0, FSM = LSU_PRI.
REQ-027 While rst is low, alu_ready and lsu_ready SHALL be 0.
REQ-028 A write accepted in the cycle reset asserts SHALL be discarded; no rf_wen pulse after reset release.

Structure
REQ-029 Arbiter state encoding (LSU_PRI, ALU_PRI) and the starve-count width constant SHALL live in the shared CPU package.
REQ-030 Output stage SHALL reuse the existing Reg sub-module (width ADDR_WIDTH+DATA_WIDTH+1, reset value 0); arbiter and counter are inline.

Verification
REQ-031 Only alu_valid, waddr=3, wdata=0xDEADBEEF -> alu_ready same cycle; next cycle rf_wen=1, rf_waddr=3, rf_wdata=0xDEADBEEF.
REQ-032 Both valid continuously, STARVE_LIMIT=3 -> grants LSU, LSU, LSU, ALU, LSU...; starve_cnt 1,2,3,0.
REQ-033 LSU write to waddr=0, wdata=0x55 -> lsu_ready=1; next cycle rf_wen=0.
REQ-034 Both valid with stall=1 for 4 cycles -> both ready 0, starve_cnt unchanged, rf_wen 0 from second stalled cycle on.
REQ-035 rst pulsed low mid-stream, between clk edges, after 2 ALU losses -> rf_wen, starve_cnt drop to 0 at once; FSM LSU_PRI; first post-reset grant goes to LSU.

Source files
------------

// File: rtl/regfile_writeback_pkg.sv
// ============================================================================
// Module  : regfile_writeback_pkg
// Brief   : Shared CPU definitions for the writeback arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_writeback_pkg;

  localparam int STARVE_CNT_W = 4;

  typedef enum logic [0:0] {
    LSU_PRI = 1'b0,
    ALU_PRI = 1'b1
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/regfile_writeback_if.sv
// ============================================================================
// Module  : regfile_writeback_if
// Brief   : ALU/LSU producer handshakes and register-file write port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_writeback_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);

  logic                  alu_valid;
  logic                  alu_ready;
  logic [ADDR_WIDTH-1:0] alu_waddr;
  logic [DATA_WIDTH-1:0] alu_wdata;

  logic                  lsu_valid;
  logic                  lsu_ready;
  logic [ADDR_WIDTH-1:0] lsu_waddr;
  logic [DATA_WIDTH-1:0] lsu_wdata;

  logic                  rf_wen;
  logic [ADDR_WIDTH-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;

  modport master (
    output alu_valid, alu_waddr, alu_wdata,
    output lsu_valid, lsu_waddr, lsu_wdata,
    input  alu_ready, lsu_ready,
    input  rf_wen, rf_waddr, rf_wdata
  );

  modport slave (
    input  alu_valid, alu_waddr, alu_wdata,
    input  lsu_valid, lsu_waddr, lsu_wdata,
    output alu_ready, lsu_ready,
    output rf_wen, rf_waddr, rf_wdata
  );

endinterface

`default_nettype wire

// File: rtl/regfile_writeback_reg.sv
// ============================================================================
// Module  : regfile_writeback_reg
// Brief   : Plain D register, asynchronous active-low reset to zero.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_writeback_reg #(
  parameter int WIDTH = 1
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic [WIDTH-1:0] d_i,
  output logic      [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
    end else begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

`default_nettype wire

// File: rtl/regfile_writeback.sv
// ============================================================================
// Module  : regfile_writeback
// Brief   : Two-producer writeback arbiter with ALU anti-starvation priority.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_writeback
  import regfile_writeback_pkg::*;
#(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 3
) (
  input  wire logic                    clk,
  input  wire logic                    rst,
  input  wire logic                    stall,
  regfile_writeback_if.slave           bus,
  output logic [STARVE_CNT_W-1:0]      starve_cnt
);

  localparam int                      OUT_W = ADDR_WIDTH + DATA_WIDTH + 1;
  localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

  arb_state_e              state_q;
  arb_state_e              state_d;
  logic [STARVE_CNT_W-1:0] starve_q;
  logic [STARVE_CNT_W-1:0] starve_d;

  logic                  grant_alu;
  logic                  grant_lsu;
  logic                  take;
  logic [ADDR_WIDTH-1:0] sel_waddr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [OUT_W-1:0]      out_d;
  logic [OUT_W-1:0]      out_q;

  // Grants double as ready; gating with rst keeps both low during reset.
  always_comb begin
    grant_alu = 1'b0;
    grant_lsu = 1'b0;
    if (rst && !stall) begin
      if (state_q == ALU_PRI) begin
        grant_alu = bus.alu_valid;
        grant_lsu = bus.lsu_valid && !bus.alu_valid;
      end else begin
        grant_lsu = bus.lsu_valid;
        grant_alu = bus.alu_valid && !bus.lsu_valid;
      end
    end
  end

  assign bus.alu_ready = grant_alu;
  assign bus.lsu_ready = grant_lsu;

  always_comb begin
    starve_d = starve_q;
    state_d  = state_q;
    if (!stall) begin
      if (grant_alu) begin
        starve_d = '0;
      end else if (bus.alu_valid && (starve_q < LIMIT)) begin
        starve_d = starve_q + 1'b1;
      end
    end
    case (state_q)
      LSU_PRI: if (starve_d == LIMIT) state_d = ALU_PRI;
      ALU_PRI: if (grant_alu)         state_d = LSU_PRI;
      default:                        state_d = LSU_PRI;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= LSU_PRI;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  assign starve_cnt = starve_q;

  assign sel_waddr = grant_alu ? bus.alu_waddr : bus.lsu_waddr;
  assign sel_wdata = grant_alu ? bus.alu_wdata : bus.lsu_wdata;

  // Writes to r0 complete the handshake but never reach the file; the
  // address/data fields keep their last value whenever no write issues.
  assign take  = (grant_alu || grant_lsu) && (sel_waddr != '0);
  assign out_d = take ? {1'b1, sel_waddr, sel_wdata}
                      : {1'b0, out_q[OUT_W-2:0]};

  regfile_writeback_reg #(
    .WIDTH (OUT_W)
  ) u_out_reg (
    .clk (clk),
    .rst (rst),
    .d_i (out_d),
    .q_o (out_q)
  );

  assign bus.rf_wen   = out_q[OUT_W-1];
  assign bus.rf_waddr = out_q[OUT_W-2 -: ADDR_WIDTH];
  assign bus.rf_wdata = out_q[DATA_WIDTH-1:0];

endmodule

`default_nettype wire

// File: tb/tb_regfile_writeback.sv
// ============================================================================
// Module  : tb_regfile_writeback
// Brief   : Directed and randomized checks of regfile_writeback vs a model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_writeback;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int LIMIT = 3;

  logic       clk;
  logic       rst;
  logic       stall;
  logic [3:0] starve_cnt;

  regfile_writeback_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  regfile_writeback #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .bus        (bus),
    .starve_cnt (starve_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: ALU "owed a turn" flag plus loss tally and last write.
  bit              m_alu_owed;
  int              m_losses;
  logic            m_wen;
  logic [AW-1:0]   m_waddr;
  logic [DW-1:0]   m_wdata;

  // Values captured by tick(): s_* observed, e_* expected.
  logic          s_ga, s_gl, s_wen;
  logic [AW-1:0] s_waddr;
  logic [DW-1:0] s_wdata;
  logic [3:0]    s_cnt;
  logic          e_ga, e_gl, e_wen;
  logic [AW-1:0] e_waddr;
  logic [DW-1:0] e_wdata;
  logic [3:0]    e_cnt;

  task automatic model_reset();
    m_alu_owed = 0;
    m_losses   = 0;
    m_wen      = 1'b0;
    m_waddr    = '0;
    m_wdata    = '0;
  endtask

  task automatic model_grants(output logic ga, output logic gl);
    ga = 1'b0;
    gl = 1'b0;
    if (rst && !stall) begin
      if (m_alu_owed) begin
        ga = bus.alu_valid;
        gl = bus.lsu_valid && !bus.alu_valid;
      end else begin
        gl = bus.lsu_valid;
        ga = bus.alu_valid && !bus.lsu_valid;
      end
    end
  endtask

  task automatic model_update(input logic ga, input logic gl);
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    a = ga ? bus.alu_waddr : bus.lsu_waddr;
    d = ga ? bus.alu_wdata : bus.lsu_wdata;
    if ((ga || gl) && a != 0) begin
      m_wen = 1'b1; m_waddr = a; m_wdata = d;
    end else begin
      m_wen = 1'b0;
    end
    if (!stall) begin
      if (ga) begin
        m_losses = 0; m_alu_owed = 0;
      end else if (bus.alu_valid) begin
        if (m_losses < LIMIT) m_losses++;
        if (m_losses == LIMIT) m_alu_owed = 1;
      end
    end
  endtask

  // One clock: sample at negedge, advance model at posedge, return at posedge+1.
  task automatic tick();
    @(negedge clk);
    model_grants(e_ga, e_gl);
    e_wen   = m_wen;
    e_waddr = m_waddr;
    e_wdata = m_wdata;
    e_cnt   = 4'(m_losses);
    s_ga    = bus.alu_ready;
    s_gl    = bus.lsu_ready;
    s_wen   = bus.rf_wen;
    s_waddr = bus.rf_waddr;
    s_wdata = bus.rf_wdata;
    s_cnt   = starve_cnt;
    @(posedge clk);
    model_update(e_ga, e_gl);
    #1;
  endtask

  task automatic drive(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input logic lv, input logic [AW-1:0] la, input logic [DW-1:0] ld);
    bus.alu_valid = av; bus.alu_waddr = aa; bus.alu_wdata = ad;
    bus.lsu_valid = lv; bus.lsu_waddr = la; bus.lsu_wdata = ld;
  endtask

  task automatic test_reset();
    rst = 1'b0; stall = 1'b0;
    drive(1'b1, 5'd7, 32'h1111_1111, 1'b1, 5'd9, 32'h2222_2222);
    model_reset();
    #3;
    checks++; if (bus.alu_ready !== 1'b0 || bus.lsu_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got alu=%b lsu=%b exp 0 0", bus.alu_ready, bus.lsu_ready); end
    checks++; if (bus.rf_wen !== 1'b0) begin
      errors++; $display("FAIL reset_wen: got %b exp 0", bus.rf_wen); end
    checks++; if (bus.rf_waddr !== '0 || bus.rf_wdata !== '0) begin
      errors++; $display("FAIL reset_addr_data: got %h/%h exp 0/0", bus.rf_waddr, bus.rf_wdata); end
    checks++; if (starve_cnt !== 4'd0) begin
      errors++; $display("FAIL reset_cnt: got %0d exp 0", starve_cnt); end
    @(posedge clk); #1;
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    @(posedge clk); #2;
    rst = 1'b1;
  endtask

  task automatic test_single_alu();
    drive(1'b1, 5'd3, 32'hDEAD_BEEF, 1'b0, '0, '0);
    tick();
    checks++; if (s_ga !== 1'b1 || s_gl !== 1'b0) begin
      errors++; $display("FAIL alu_only_ready: got alu=%b lsu=%b exp 1 0", s_ga, s_gl); end
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    tick();
    checks++; if (s_wen !== 1'b1 || s_waddr !== 5'd3 || s_wdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL alu_only_write: got wen=%b a=%0d d=%h exp 1 3 deadbeef",
                         s_wen, s_waddr, s_wdata); end
    tick();
    checks++; if (s_wen !== 1'b0 || s_waddr !== 5'd3) begin
      errors++; $display("FAIL alu_only_pulse: got wen=%b a=%0d exp 0 3", s_wen, s_waddr); end
  endtask

  task automatic test_starvation();
    logic [7:0] exp_alu_win;
    logic [3:0] exp_cnt [8];
    exp_alu_win = 8'b1000_1000;
    exp_cnt = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 4'd1, 4'd2, 4'd3};
    drive(1'b1, 5'd10, $urandom, 1'b1, 5'd20, $urandom);
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (s_ga !== exp_alu_win[i] || s_gl !== !exp_alu_win[i]) begin
        errors++; $display("FAIL starve_grant[%0d]: got alu=%b lsu=%b exp alu=%b",
                           i, s_ga, s_gl, exp_alu_win[i]); end
      checks++; if (s_cnt !== exp_cnt[i]) begin
        errors++; $display("FAIL starve_cnt[%0d]: got %0d exp %0d", i, s_cnt, exp_cnt[i]); end
      if (i > 0) begin
        checks++; if (s_wen !== 1'b1) begin
          errors++; $display("FAIL starve_wen[%0d]: got %b exp 1", i, s_wen); end
      end
    end
  endtask

  task automatic test_zero_addr();
    drive(1'b0, '0, '0, 1'b1, 5'd0, 32'h55);
    tick();
    checks++; if (s_gl !== 1'b1) begin
      errors++; $display("FAIL zero_addr_ready: got %b exp 1", s_gl); end
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    tick();
    checks++; if (s_wen !== 1'b0) begin
      errors++; $display("FAIL zero_addr_wen: got %b exp 0", s_wen); end
    checks++; if (s_waddr !== e_waddr || s_wdata !== e_wdata) begin
      errors++; $display("FAIL zero_addr_hold: got %h/%h exp %h/%h", s_waddr, s_wdata, e_waddr, e_wdata); end
  endtask

  task automatic test_stall();
    drive(1'b1, 5'd4, 32'hA5A5_0001, 1'b1, 5'd6, 32'h5A5A_0002);
    tick();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (s_ga !== 1'b0 || s_gl !== 1'b0) begin
        errors++; $display("FAIL stall_ready[%0d]: got alu=%b lsu=%b exp 0 0", i, s_ga, s_gl); end
      checks++; if (s_cnt !== 4'd1) begin
        errors++; $display("FAIL stall_cnt[%0d]: got %0d exp 1", i, s_cnt); end
      checks++; if (s_wen !== (i == 0)) begin
        errors++; $display("FAIL stall_wen[%0d]: got %b exp %b", i, s_wen, (i == 0)); end
    end
    stall = 1'b0;
  endtask

  task automatic test_reset_midstream();
    drive(1'b1, 5'd12, 32'hCAFE_0001, 1'b1, 5'd13, 32'hCAFE_0002);
    tick();
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    checks++; if (bus.rf_wen !== 1'b0 || starve_cnt !== 4'd0) begin
      errors++; $display("FAIL midreset_async: got wen=%b cnt=%0d exp 0 0", bus.rf_wen, starve_cnt); end
    checks++; if (bus.alu_ready !== 1'b0 || bus.lsu_ready !== 1'b0) begin
      errors++; $display("FAIL midreset_ready: got alu=%b lsu=%b exp 0 0", bus.alu_ready, bus.lsu_ready); end
    @(posedge clk); #2;
    rst = 1'b1;
    tick();
    checks++; if (s_gl !== 1'b1 || s_ga !== 1'b0) begin
      errors++; $display("FAIL midreset_first_grant: got alu=%b lsu=%b exp 0 1", s_ga, s_gl); end
    checks++; if (s_wen !== 1'b0 || s_cnt !== 4'd0) begin
      errors++; $display("FAIL midreset_quiet: got wen=%b cnt=%0d exp 0 0", s_wen, s_cnt); end
  endtask

  task automatic test_random();
    logic          av, lv;
    logic [AW-1:0] aa, la;
    logic [DW-1:0] ad, ld;
    av = 1'b0; lv = 1'b0; aa = '0; la = '0; ad = '0; ld = '0;
    for (int i = 0; i < 400; i++) begin
      // Producers hold a pending request stable until it is accepted.
      if (!av || e_ga) begin
        av = ($urandom % 3) != 0;
        aa = ($urandom % 8 == 0) ? '0 : AW'($urandom);
        ad = $urandom;
      end
      if (!lv || e_gl) begin
        lv = ($urandom % 2) != 0;
        la = ($urandom % 8 == 0) ? '0 : AW'($urandom);
        ld = $urandom;
      end
      stall = ($urandom % 5) == 0;
      drive(av, aa, ad, lv, la, ld);
      tick();
      checks++; if (s_ga !== e_ga || s_gl !== e_gl) begin
        errors++; $display("FAIL rnd_ready[%0d]: got alu=%b lsu=%b exp %b %b", i, s_ga, s_gl, e_ga, e_gl); end
      checks++; if (s_wen !== e_wen || s_waddr !== e_waddr || s_wdata !== e_wdata) begin
        errors++; $display("FAIL rnd_write[%0d]: got %b/%h/%h exp %b/%h/%h",
                           i, s_wen, s_waddr, s_wdata, e_wen, e_waddr, e_wdata); end
      checks++; if (s_cnt !== e_cnt) begin
        errors++; $display("FAIL rnd_cnt[%0d]: got %0d exp %0d", i, s_cnt, e_cnt); end
    end
    stall = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_alu();
    test_starvation();
    test_zero_addr();
    test_stall();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
